// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - shift-and-add sequential unsigned multiplier with gate-level ripple-carry adder
`timescale 1ns/1ps

module seq_full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    logic t_xy;
    logic t_and;
    logic t_carry;

    xor g_x0 (t_xy, x, y);
    xor g_x1 (s, t_xy, ci);
    and g_a0 (t_and, x, y);
    and g_a1 (t_carry, t_xy, ci);
    or  g_o0 (co, t_and, t_carry);
endmodule

module seq_ripple_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:0] carry;

    assign carry[0] = 1'b0;
    assign cout     = carry[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        seq_full_adder u_fa (
            .x  (x[i]),
            .y  (y[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end
endmodule

module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] p_hi;
    logic [WIDTH-1:0] p_lo;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             carry;

    // Multiplier bits are consumed from the bottom of p_lo as the product shifts in from above.
    assign addend  = p_lo[0] ? a_reg : '0;
    assign product = {p_hi, p_lo};

    seq_ripple_adder #(.WIDTH(WIDTH)) u_adder (
        .x    (p_hi),
        .y    (addend),
        .sum  (sum),
        .cout (carry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            a_reg <= '0;
            p_hi  <= '0;
            p_lo  <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg <= a;
                        p_hi  <= '0;
                        p_lo  <= b;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    p_hi  <= {carry, sum[WIDTH-1:1]};
                    p_lo  <= {sum[0], p_lo[WIDTH-1:1]};
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - randomized scoreboard bench for seq_multiplier
`timescale 1ns/1ps

module tb_seq_multiplier;
    localparam int W = 32;

    typedef struct {
        logic [2*W-1:0] prod;
        logic [W-1:0]   b;
        int             acc;
        int             fin;
    } op_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    op_t            q[$];
    int             cyc = 0;
    int             free_at = 0;
    logic [2*W-1:0] hold = '0;
    int             n_checks = 0;
    int             n_errors = 0;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (op_a),
        .b       (op_b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #1000 clk = ~clk;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: one operation in flight, accepted only once the previous one has fully retired.
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            q.delete();
            hold    = '0;
            free_at = cyc + 1;
        end else if (start && cyc >= free_at) begin
            q.push_back('{prod: {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b}, b: op_b, acc: cyc, fin: cyc + W});
            free_at = cyc + W + 2;
        end
    end

    always @(negedge clk) begin
        logic exp_busy;
        logic exp_done;
        if (cyc > 0) begin
            exp_busy = 1'b0;
            exp_done = 1'b0;
            if (q.size() > 0 && cyc > q[0].fin) begin
                n_checks++;
                n_errors++;
                $display("FAIL done_missing at cycle %0d: no done seen, expected at cycle %0d", cyc, q[0].fin);
                void'(q.pop_front());
            end
            if (q.size() > 0) begin
                exp_busy = (cyc < q[0].fin);
                exp_done = (cyc == q[0].fin);
            end
            check_bit("busy", busy, exp_busy);
            check_bit("done", done, exp_done);
            if (q.size() > 0) begin
                if (cyc == q[0].acc) begin
                    check_word("load", product, {{W{1'b0}}, q[0].b});
                end else if (cyc == q[0].fin) begin
                    check_word("product", product, q[0].prod);
                    hold = q[0].prod;
                    void'(q.pop_front());
                end
            end else begin
                check_word("hold", product, hold);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [W-1:0] x, input logic [W-1:0] y);
        op_a  = x;
        op_b  = y;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return '1;
            2:       return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        tick(3);
        reset = 1'b0;

        pulse(32'd3, 32'd5);
        tick(38);
        pulse(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick(38);
        pulse(32'd0, 32'h1234_5678);
        tick(38);

        // Start during RUN is ignored; operand changes after acceptance are ignored.
        pulse(32'd7, 32'd6);
        tick(9);
        pulse(32'd2, 32'd2);
        op_a = 32'hDEAD_BEEF;
        op_b = 32'h0BAD_F00D;
        tick(30);

        // Abort mid-operation, then start on the first edge after reset.
        pulse(32'd11, 32'd13);
        tick(9);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        pulse(32'd9, 32'd9);
        tick(38);

        // Start held high: back-to-back operations with changing operands.
        start = 1'b1;
        for (int i = 0; i < 140; i++) begin
            op_a = pick();
            op_b = pick();
            tick(1);
        end
        start = 1'b0;
        tick(38);

        for (int n = 0; n < 25; n++) begin
            pulse(pick(), pick());
            for (int c = 0; c < 33 + int'($urandom_range(0, 4)); c++) begin
                if ($urandom_range(0, 7) == 0) begin
                    pulse(pick(), pick());
                end else begin
                    tick(1);
                end
            end
            if (n == 12) begin
                pulse(pick(), pick());
                tick(int'($urandom_range(1, 31)));
                reset = 1'b1;
                tick(1);
                reset = 1'b0;
            end
        end
        tick(40);

        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d operations outstanding, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
